// File: rtl/fft_merge_out_buffer.sv
// -----------------------------------------------------------------------------
// fft_merge_out_buffer
//
// Output stage behind the two-half FFT merge (butterfly) stage. Each accepted
// input cycle carries the pair X[k] / X[k+NFFT/2] for k = 0..NFFT/2-1 in order.
// The pair is stored in a low bank and a high bank. Once a full frame has been
// captured, the block streams X[0..NFFT-1] in natural order over a valid/ready
// handshake, and it raises a one-cycle frame-done pulse toward the merge stage.
//
// Ports
//   i_clk                      clock, all logic on the rising edge
//   i_reset_n                  asynchronous active-low reset
//   i_clear                    synchronous abort: flush frame, return to IDLE,
//                              clear o_overflow
//   i_valid                    input pair valid this cycle
//   i_data_lo_i / i_data_lo_q  X[k] I/Q
//   i_data_hi_i / i_data_hi_q  X[k+NFFT/2] I/Q
//   o_mutDone                  1-cycle pulse: frame fully captured
//   o_busy                     1 while draining; inputs are dropped
//   o_valid / i_ready          output handshake
//   o_data_i / o_data_q        output sample X[o_index]
//   o_index                    bin index of the output sample
//   o_last                     marks o_index == NFFT-1
//   o_overflow                 sticky: an input arrived while busy and was dropped
// -----------------------------------------------------------------------------
module fft_merge_out_buffer #(
  parameter int SIZE_BUFFER   = 3,
  parameter int SIZE_OUT_DATA = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic [SIZE_OUT_DATA-1:0] i_data_lo_i,
  input  logic [SIZE_OUT_DATA-1:0] i_data_lo_q,
  input  logic [SIZE_OUT_DATA-1:0] i_data_hi_i,
  input  logic [SIZE_OUT_DATA-1:0] i_data_hi_q,
  output logic                     o_mutDone,
  output logic                     o_busy,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [SIZE_OUT_DATA-1:0] o_data_i,
  output logic [SIZE_OUT_DATA-1:0] o_data_q,
  output logic [SIZE_BUFFER-1:0]   o_index,
  output logic                     o_last,
  output logic                     o_overflow
);

  localparam int NFFT = 1 << SIZE_BUFFER;
  localparam int HALF = NFFT / 2;
  // Bank address width; kept at least 1 bit so a one-entry bank still has a port.
  localparam int AW   = (SIZE_BUFFER > 1) ? (SIZE_BUFFER - 1) : 1;

  localparam logic [AW-1:0]          LAST_WR   = AW'(HALF - 1);
  localparam logic [SIZE_BUFFER-1:0] LAST_IDX  = SIZE_BUFFER'(NFFT - 1);
  localparam logic [SIZE_BUFFER-1:0] HALF_MASK = SIZE_BUFFER'(HALF - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                   state_r;
  logic [AW-1:0]            wr_cnt_r;
  logic [SIZE_BUFFER-1:0]   rd_idx_r;

  logic [SIZE_OUT_DATA-1:0] lo_i_mem_r [HALF];
  logic [SIZE_OUT_DATA-1:0] lo_q_mem_r [HALF];
  logic [SIZE_OUT_DATA-1:0] hi_i_mem_r [HALF];
  logic [SIZE_OUT_DATA-1:0] hi_q_mem_r [HALF];

  logic                     accept_s;
  logic                     last_wr_s;
  logic                     handshake_s;
  logic                     final_hs_s;
  logic                     load_s;
  logic [SIZE_BUFFER-1:0]   rd_masked_s;
  logic [AW-1:0]            rd_addr_s;
  logic                     rd_hi_s;
  logic [SIZE_OUT_DATA-1:0] rd_data_i_s;
  logic [SIZE_OUT_DATA-1:0] rd_data_q_s;

  // Control decode: write acceptance, drain handshake and next-sample load.
  always_comb begin
    accept_s    = i_valid && (state_r != ST_DRAIN) && !i_clear;
    last_wr_s   = (wr_cnt_r == LAST_WR);
    handshake_s = o_valid && i_ready;
    final_hs_s  = handshake_s && o_last;
    // Load a sample when the output register is empty (first drain cycle)
    // or being consumed, except on the handshake that retires the last one.
    load_s      = (state_r == ST_DRAIN) && (!o_valid || i_ready) && !final_hs_s;
  end

  // Read-side addressing: the top index bit selects the bank, the rest is the address.
  always_comb begin
    rd_masked_s = rd_idx_r & HALF_MASK;
    rd_addr_s   = rd_masked_s[AW-1:0];
    rd_hi_s     = rd_idx_r[SIZE_BUFFER-1];
    if (rd_hi_s) begin
      rd_data_i_s = hi_i_mem_r[rd_addr_s];
      rd_data_q_s = hi_q_mem_r[rd_addr_s];
    end else begin
      rd_data_i_s = lo_i_mem_r[rd_addr_s];
      rd_data_q_s = lo_q_mem_r[rd_addr_s];
    end
  end

  // Bank write port; contents need no reset since they are always rewritten before being read.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      lo_i_mem_r[wr_cnt_r] <= i_data_lo_i;
      lo_q_mem_r[wr_cnt_r] <= i_data_lo_q;
      hi_i_mem_r[wr_cnt_r] <= i_data_hi_i;
      hi_q_mem_r[wr_cnt_r] <= i_data_hi_q;
    end
  end

  // Frame FSM with registered outputs: capture, frame-done pulse, drain and overflow flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= ST_IDLE;
      wr_cnt_r   <= '0;
      rd_idx_r   <= '0;
      o_mutDone  <= 1'b0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_data_i   <= '0;
      o_data_q   <= '0;
      o_index    <= '0;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      // Abort: any input presented together with the clear is discarded.
      state_r    <= ST_IDLE;
      wr_cnt_r   <= '0;
      rd_idx_r   <= '0;
      o_mutDone  <= 1'b0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_data_i   <= '0;
      o_data_q   <= '0;
      o_index    <= '0;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_mutDone <= 1'b0;
      // Inputs are never taken while draining, including the final handshake cycle.
      if (i_valid && (state_r == ST_DRAIN)) begin
        o_overflow <= 1'b1;
      end
      case (state_r)
        ST_IDLE, ST_FILL: begin
          if (i_valid) begin
            // wr_cnt is 0 in IDLE, so a one-entry bank completes on the first pair.
            if (last_wr_s) begin
              state_r   <= ST_DRAIN;
              wr_cnt_r  <= '0;
              o_mutDone <= 1'b1;
              o_busy    <= 1'b1;
            end else begin
              state_r  <= ST_FILL;
              wr_cnt_r <= wr_cnt_r + AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (final_hs_s) begin
            state_r  <= ST_IDLE;
            rd_idx_r <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_busy   <= 1'b0;
          end else if (load_s) begin
            o_valid  <= 1'b1;
            o_data_i <= rd_data_i_s;
            o_data_q <= rd_data_q_s;
            o_index  <= rd_idx_r;
            o_last   <= (rd_idx_r == LAST_IDX);
            rd_idx_r <= rd_idx_r + SIZE_BUFFER'(1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          wr_cnt_r <= '0;
          rd_idx_r <= '0;
          o_valid  <= 1'b0;
          o_last   <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_merge_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_fft_merge_out_buffer
//
// Scoreboard bench for fft_merge_out_buffer with NFFT = 8. Stimulus drives
// inputs just after the rising edge; a monitor on the falling edge keeps a
// frame-level reference model (captured pairs, expected output queue, busy and
// overflow flags) and compares every DUT output against it.
// -----------------------------------------------------------------------------
module tb_fft_merge_out_buffer;

  localparam int SB   = 3;
  localparam int W    = 16;
  localparam int NFFT = 1 << SB;
  localparam int HALF = NFFT / 2;

  logic          clk;
  logic          rst_n;
  logic          i_clear;
  logic          i_valid;
  logic [W-1:0]  i_data_lo_i;
  logic [W-1:0]  i_data_lo_q;
  logic [W-1:0]  i_data_hi_i;
  logic [W-1:0]  i_data_hi_q;
  logic          o_mutDone;
  logic          o_busy;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_data_i;
  logic [W-1:0]  o_data_q;
  logic [SB-1:0] o_index;
  logic          o_last;
  logic          o_overflow;

  fft_merge_out_buffer #(.SIZE_BUFFER(SB), .SIZE_OUT_DATA(W)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_clear     (i_clear),
    .i_valid     (i_valid),
    .i_data_lo_i (i_data_lo_i),
    .i_data_lo_q (i_data_lo_q),
    .i_data_hi_i (i_data_hi_i),
    .i_data_hi_q (i_data_hi_q),
    .o_mutDone   (o_mutDone),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data_i    (o_data_i),
    .o_data_q    (o_data_q),
    .o_index     (o_index),
    .o_last      (o_last),
    .o_overflow  (o_overflow)
  );

  typedef struct packed {
    logic [W-1:0]  di;
    logic [W-1:0]  dq;
    logic [SB-1:0] idx;
    logic          last;
  } samp_t;

  samp_t        exp_q[$];
  int           n_checks;
  int           n_fail;
  bit           busy_m;
  bit           ovf_m;
  bit           mut_pend;
  int           lat_cnt;
  int           fill_cnt;
  logic [W-1:0] f_lo_i [HALF];
  logic [W-1:0] f_lo_q [HALF];
  logic [W-1:0] f_hi_i [HALF];
  logic [W-1:0] f_hi_q [HALF];
  int           ready_mode;
  int           rdy_phase;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    busy_m   = 1'b0;
    ovf_m    = 1'b0;
    mut_pend = 1'b0;
    lat_cnt  = 0;
    fill_cnt = 0;
  endtask

  // Reference model and monitor: evaluated mid-cycle, describing the coming rising edge.
  always @(negedge clk) begin : monitor
    bit    drop;
    samp_t s;
    if (!rst_n) begin
      check("reset_outputs",
            64'({o_valid, o_busy, o_mutDone, o_overflow, o_last, o_index, o_data_i, o_data_q}),
            64'(0));
      flush_model();
    end else begin
      check("busy", 64'(o_busy), 64'(busy_m));
      check("overflow", 64'(o_overflow), 64'(ovf_m));
      check("mutdone", 64'(o_mutDone), 64'(mut_pend));
      mut_pend = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) check("first_out_latency", 64'(o_valid), 64'(1));
      end
      if (o_valid) begin
        check("queue_has_sample", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0)
          check("sample", 64'({o_data_i, o_data_q, o_index, o_last}), 64'(exp_q[0]));
      end else begin
        check("last_without_valid", 64'(o_last), 64'(0));
      end
      if (i_clear) begin
        flush_model();
      end else begin
        drop = busy_m;
        if (o_valid && i_ready && exp_q.size() > 0) begin
          s = exp_q.pop_front();
          if (s.last) busy_m = 1'b0;
        end
        if (i_valid) begin
          if (drop) begin
            ovf_m = 1'b1;
          end else begin
            f_lo_i[fill_cnt] = i_data_lo_i;
            f_lo_q[fill_cnt] = i_data_lo_q;
            f_hi_i[fill_cnt] = i_data_hi_i;
            f_hi_q[fill_cnt] = i_data_hi_q;
            fill_cnt++;
            if (fill_cnt == HALF) begin
              // Natural order: first half from the low inputs, second half from the high ones.
              for (int n = 0; n < NFFT; n++) begin
                s.di   = (n < HALF) ? f_lo_i[n] : f_hi_i[n - HALF];
                s.dq   = (n < HALF) ? f_lo_q[n] : f_hi_q[n - HALF];
                s.idx  = SB'(n);
                s.last = (n == NFFT - 1);
                exp_q.push_back(s);
              end
              fill_cnt = 0;
              busy_m   = 1'b1;
              mut_pend = 1'b1;
              lat_cnt  = 2;
            end
          end
        end
      end
    end
  end

  // Downstream ready generator.
  initial begin
    i_ready   = 1'b1;
    rdy_phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: i_ready = 1'b1;
        1: begin
          i_ready = (rdy_phase % 3 == 0);
          rdy_phase++;
        end
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    i_valid     = v;
    i_data_lo_i = a;
    i_data_lo_q = b;
    i_data_hi_i = c;
    i_data_hi_q = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, '0, '0);
  endtask

  task automatic junk_pair();
    step(1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
  endtask

  // mode 0: directed values lo=k+1, hi=k+0x11; otherwise random data.
  task automatic send_frame(input int gap, input int mode);
    for (int k = 0; k < HALF; k++) begin
      if (mode == 0)
        step(1'b1, W'(k + 1), W'(k + 16'h101), W'(k + 16'h11), W'(k + 16'h111));
      else
        junk_pair();
      if (gap > 0 && k < HALF - 1) idle(gap);
    end
    idle(1);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || busy_m) && c < budget) begin
      idle(1);
      c++;
    end
    check("drain_completes", 64'(exp_q.size() == 0 && !busy_m), 64'(1));
  endtask

  task automatic do_clear(input bit with_valid);
    @(posedge clk);
    #1;
    i_clear = 1'b1;
    i_valid = with_valid;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    n_checks    = 0;
    n_fail      = 0;
    ready_mode  = 0;
    rst_n       = 1'b0;
    i_clear     = 1'b0;
    i_valid     = 1'b0;
    i_data_lo_i = '0;
    i_data_lo_q = '0;
    i_data_hi_i = '0;
    i_data_hi_q = '0;
    flush_model();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Back-to-back directed frame.
    send_frame(0, 0);
    wait_done(40);

    // Same frame with idle gaps between pairs.
    send_frame(3, 0);
    wait_done(40);

    // Stalling downstream.
    ready_mode = 1;
    send_frame(0, 0);
    wait_done(80);
    ready_mode = 0;
    idle(1);

    // Inputs during drain and on the final handshake cycle.
    send_frame(0, 0);
    idle(2);
    junk_pair();
    idle(1);
    c = 0;
    while (!(o_valid && o_last) && c < 40) begin
      idle(1);
      c++;
    end
    check("saw_last", 64'(o_valid && o_last), 64'(1));
    i_valid     = 1'b1;
    i_data_lo_i = 16'hdead;
    idle(1);
    wait_done(40);
    send_frame(1, 1);
    wait_done(40);

    // Reset mid-frame, then a fresh frame.
    step(1'b1, 16'h0aaa, 16'h0bbb, 16'h0ccc, 16'h0ddd);
    step(1'b1, 16'h1aaa, 16'h1bbb, 16'h1ccc, 16'h1ddd);
    idle(1);
    do_reset(3);
    idle(2);
    send_frame(0, 1);
    wait_done(40);

    // Clear mid-fill (with a simultaneous input), then a full frame.
    junk_pair();
    junk_pair();
    do_clear(1'b1);
    send_frame(0, 0);
    wait_done(40);

    // Clear mid-drain after an overflow, then a full frame.
    send_frame(0, 1);
    idle(1);
    junk_pair();
    idle(2);
    do_clear(1'b0);
    idle(2);
    send_frame(2, 1);
    wait_done(40);

    // Randomized frames with random gaps, ready patterns and drain-time inputs.
    for (int f = 0; f < 12; f++) begin
      ready_mode = $urandom_range(0, 2);
      send_frame($urandom_range(0, 3), 1);
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(0, 4));
        junk_pair();
        idle(1);
      end
      wait_done(200);
      ready_mode = 0;
      idle($urandom_range(1, 3));
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
